// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Holds the FSM state encoding, the cfg_len width derivation and the masked compare.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HIT  = 2'd2
  } state_t;

  // Widest pattern the masked compare can handle.
  localparam int CMP_W = 64;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // True when the low 'len' bits of a and b are equal.
  function automatic logic masked_eq(input logic [CMP_W-1:0] a,
                                     input logic [CMP_W-1:0] b,
                                     input int               len);
    logic [CMP_W-1:0] mask;
    mask = (len >= CMP_W) ? '1 : ((CMP_W'(1) << len) - CMP_W'(1));
    return ((a ^ b) & mask) == '0;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter; clear and increment in the same cycle yields 1.
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= inc ? CNT_W'(1) : '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector (Moore), overlapping or not,
// with valid-qualified input and a saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cnt_clr,
  output logic               detect,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  state_t             state_reg, state_next;
  logic [MAX_LEN-1:0] pattern_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               overlap_reg;
  logic [MAX_LEN-1:0] hist_reg, hist_next;
  logic [LEN_W-1:0]   fill_reg, fill_next;
  logic [MAX_LEN-1:0] shifted;
  logic [LEN_W-1:0]   fill_sat;
  logic               fill_full;
  logic               cfg_ok;
  logic               match;

  assign cfg_ok    = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);
  assign shifted   = {hist_reg[MAX_LEN-2:0], in};
  // fill_full: after this bit at least len bits have arrived since the last restart.
  assign fill_full = (int'(fill_reg) + 1) >= int'(len_reg);
  assign fill_sat  = fill_full ? len_reg : fill_reg + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hist_next  = hist_reg;
    fill_next  = fill_reg;
    match      = 1'b0;
    if (cfg_load) begin
      hist_next  = '0;
      fill_next  = '0;
      state_next = cfg_ok ? SCAN : IDLE;
    end else if (state_reg != IDLE) begin
      if (in_valid) begin
        hist_next  = shifted;
        match      = fill_full &&
                     masked_eq(CMP_W'(shifted), CMP_W'(pattern_reg), int'(len_reg));
        // Non-overlap restarts the fill so no completed bit is reused.
        fill_next  = (match && !overlap_reg) ? '0 : fill_sat;
        state_next = match ? HIT : SCAN;
      end else if (state_reg == HIT) begin
        state_next = SCAN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_reg <= '0;
      len_reg     <= '0;
      overlap_reg <= 1'b0;
      hist_reg    <= '0;
      fill_reg    <= '0;
    end else begin
      if (cfg_load) begin
        pattern_reg <= cfg_pattern;
        len_reg     <= cfg_len;
        overlap_reg <= cfg_overlap;
      end
      hist_reg <= hist_next;
      fill_reg <= fill_next;
    end
  end

  seq_match_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (match),
    .count (match_count)
  );

  assign detect = (state_reg == HIT);
  assign armed  = (state_reg != IDLE);

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: queue-based reference model checked every
// cycle, plus literal per-bit detect and count expectations from the test plan.
module tb_seq_detector_prog;

  localparam int MAXL = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       in_valid;
  logic       din;
  logic       cnt_clr;
  logic       detect, detect2;
  logic       armed, armed2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detector_prog #(.MAX_LEN(MAXL), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in(din),
    .cnt_clr(cnt_clr), .detect(detect), .match_count(match_count), .armed(armed)
  );

  seq_detector_prog #(.MAX_LEN(MAXL), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in(din),
    .cnt_clr(cnt_clr), .detect(detect2), .match_count(match_count2), .armed(armed2)
  );

  // Reference model: bits accepted since the last restart, matched against the pattern tail.
  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ov, m_armed, m_det;
  int         m_cnt8, m_cnt2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_pat = '0; m_len = 0; m_ov = 0; m_armed = 0; m_det = 0;
      m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      bit hit;
      hit = 0;
      if (cfg_load) begin
        m_pat   = cfg_pattern;
        m_len   = int'(cfg_len);
        m_ov    = cfg_overlap;
        m_armed = (m_len >= 1) && (m_len <= MAXL);
        mq.delete();
      end else if (m_armed && in_valid) begin
        mq.push_back(din);
        if (mq.size() > MAXL) void'(mq.pop_front());
        if (mq.size() >= m_len) begin
          hit = 1;
          for (int i = 0; i < m_len; i++)
            if (mq[mq.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 0;
        end
        if (hit && !m_ov) mq.delete();
      end
      m_det = hit;
      if (cnt_clr) begin
        m_cnt8 = hit ? 1 : 0;
        m_cnt2 = hit ? 1 : 0;
      end else if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("model_detect", int'(detect), int'(m_det));
      check("model_armed", int'(armed), int'(m_armed));
      check("model_count8", int'(match_count), m_cnt8);
      check("model_detect2", int'(detect2), int'(m_det));
      check("model_armed2", int'(armed2), int'(m_armed));
      check("model_count2", int'(match_count2), m_cnt2);
    end
  end

  task automatic feed(input bit v, input bit b, input bit exp_det);
    in_valid = v;
    din      = b;
    @(negedge clk);
    $display("bit v=%0b in=%0b detect=%0b count=%0d", v, b, detect, match_count);
    check("lit_detect", int'(detect), int'(exp_det));
  endtask

  task automatic load(input logic [7:0] pat, input int len, input bit ov,
                      input bit v, input bit b, input bit exp_armed);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = 4'(len);
    cfg_overlap = ov;
    in_valid    = v;
    din         = b;
    @(negedge clk);
    cfg_load = 1'b0;
    in_valid = 1'b0;
    $display("load pat=%h len=%0d ov=%0b armed=%0b", pat, len, ov, armed);
    check("lit_armed", int'(armed), int'(exp_armed));
    check("lit_load_detect", int'(detect), 0);
  endtask

  task automatic clear_count();
    cnt_clr  = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    cnt_clr = 1'b0;
    $display("clr count=%0d", match_count);
    check("lit_clr", int'(match_count), 0);
  endtask

  initial begin
    rst_n = 1'b0; cfg_load = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    in_valid = 0; din = 0; cnt_clr = 0;
    #12;
    check("rst_detect", int'(detect), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_count", int'(match_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    feed(1, 1, 0);
    check("idle_armed", int'(armed), 0);

    // 1: 101 non-overlap
    load(8'h05, 3, 0, 0, 0, 1);
    feed(1, 1, 0); feed(1, 0, 0); feed(1, 1, 1); feed(1, 0, 0); feed(1, 1, 0);
    check("t1_count", int'(match_count), 1);
    check("t1_model_pin", m_cnt8, 1);

    // 2: 101 overlap
    clear_count();
    load(8'h05, 3, 1, 0, 0, 1);
    feed(1, 1, 0); feed(1, 0, 0); feed(1, 1, 1); feed(1, 0, 0); feed(1, 1, 1);
    check("t2_count", int'(match_count), 2);

    // 3: 11 overlap then non-overlap
    clear_count();
    load(8'h03, 2, 1, 0, 0, 1);
    feed(1, 1, 0); feed(1, 1, 1); feed(1, 1, 1); feed(1, 1, 1);
    feed(0, 0, 0);
    check("t3a_count", int'(match_count), 3);
    check("t3a_model_pin", m_cnt8, 3);
    clear_count();
    load(8'h03, 2, 0, 0, 0, 1);
    feed(1, 1, 0); feed(1, 1, 1); feed(1, 1, 0); feed(1, 1, 1);
    check("t3b_count", int'(match_count), 2);

    // 4: gaps on in_valid
    clear_count();
    load(8'h05, 3, 0, 0, 0, 1);
    feed(1, 1, 0); feed(0, 1, 0); feed(1, 0, 0); feed(0, 1, 0); feed(0, 1, 0);
    feed(1, 1, 1); feed(0, 0, 0);
    check("t4_count", int'(match_count), 1);

    // 5: reload mid-match (with a discarded same-cycle bit), then invalid lengths
    clear_count();
    load(8'h05, 3, 0, 0, 0, 1);
    feed(1, 1, 0); feed(1, 0, 0);
    load(8'h06, 4, 0, 1, 1, 1);
    feed(1, 0, 0); feed(1, 1, 0); feed(1, 1, 0); feed(1, 0, 1);
    check("t5_count", int'(match_count), 1);
    load(8'h01, 0, 0, 0, 0, 0);
    feed(1, 1, 0); feed(1, 1, 0);
    load(8'h01, 9, 1, 0, 0, 0);
    feed(1, 1, 0); feed(1, 1, 0);
    check("t5_idle_count", int'(match_count), 1);

    // 6: len=1, saturation, clear-with-match, async reset mid-stream
    clear_count();
    load(8'h01, 1, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) feed(1, 1, 1);
    check("t6_count8", int'(match_count), 5);
    check("t6_sat2", int'(match_count2), 3);
    check("t6_model_pin", m_cnt2, 3);
    cnt_clr = 1'b1; in_valid = 1'b1; din = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0; in_valid = 1'b0;
    $display("clr+match count=%0d count2=%0d", match_count, match_count2);
    check("t6_clr_inc8", int'(match_count), 1);
    check("t6_clr_inc2", int'(match_count2), 1);
    load(8'h01, 1, 0, 0, 0, 1);
    feed(1, 1, 1); feed(1, 0, 0); feed(1, 1, 1);
    check("t6_len1_nov", int'(match_count), 3);
    load(8'h05, 3, 0, 0, 0, 1);
    feed(1, 1, 0); feed(1, 1, 0); feed(1, 0, 0); feed(1, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset detect=%0b count=%0d armed=%0b", detect, match_count, armed);
    check("arst_detect", int'(detect), 0);
    check("arst_count", int'(match_count), 0);
    check("arst_count2", int'(match_count2), 0);
    check("arst_armed", int'(armed), 0);
    @(negedge clk);
    rst_n = 1'b1;
    feed(1, 1, 0); feed(1, 0, 0); feed(1, 1, 0);
    check("post_rst_armed", int'(armed), 0);
    check("post_rst_count", int'(match_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Runtime-programmable serial pattern detector; the parametrised successor of the fixed "101" Moore detector.
- Pattern length is programmable from 1 to MAX_LEN bits.
- Overlapping or non-overlapping detection is selectable at run time.
- Input is qualified by a valid strobe; a saturating match counter is included.
- Sits behind a serial line front-end. Control logic configures it and reads detect/match_count.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, width of the saturating match counter (>=1).
- LEN_W, $clog2(MAX_LEN+1), width of cfg_len (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_load  in  1  latch cfg_pattern/cfg_len/cfg_overlap this cycle.
- cfg_pattern  in  MAX_LEN  pattern bits; bit [cfg_len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  pattern length; valid range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- in_valid  in  1  qualifies the serial bit on in.
- in  in  1  serial input bit.
- cnt_clr  in  1  synchronous clear of match_count.
- detect  out  1  Moore output; high for the cycle following each completing bit.
- match_count  out  CNT_W  number of matches; saturates at all-ones.
- armed  out  1  high when a valid configuration is loaded (state != IDLE).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, pattern/len/overlap/history/fill=0, detect=0, match_count=0, armed=0.
- FSM states: IDLE (no valid config), SCAN (hunting), HIT (match just completed). detect = (state==HIT); armed = (state!=IDLE). Outputs are decoded from state only.
- cfg_load (highest priority):
  - Latch pattern, len and overlap; clear history and fill.
  - Next state is SCAN if 1<=cfg_len<=MAX_LEN, otherwise IDLE.
  - A bit presented with in_valid in the same cycle is discarded.
  - match_count is unaffected.
- IDLE: ignore in_valid. Leave only via cfg_load.
- Bit acceptance: when armed and in_valid=1, the bit is shifted into the history register (newest bit at [0]); fill increments, saturating at len.
- Match condition: (fill_prev+1 >= len) AND the low len bits of the new history equal the low len bits of the pattern.
  - On match: next state=HIT; match_count increments, saturating.
  - Non-overlap mode: fill cleared to 0, so the next bit starts a fresh match. That bit is NOT discarded; it is evaluated normally.
  - Overlap mode: fill is kept, so matching bits can be shared by consecutive matches.
- No match on an accepted bit: next state=SCAN.
- HIT with in_valid=0: next state=SCAN. detect is exactly one cycle per match.
- HIT with in_valid=1: evaluate the bit as in SCAN, so back-to-back matches give consecutive detect cycles.
- SCAN with in_valid=0: state, history and fill hold.
- Latency: a completing bit sampled at edge N gives detect high during cycle N+1. match_count is updated at the same edge.
- cnt_clr:
  - Clears match_count.
  - If a match occurs in the same cycle, match_count becomes 1.
  - Saturated count stays at all-ones until cleared.
- len=1: every accepted bit equal to pattern[0] is a match, in both modes.
- Mid-operation reset: all state returns to reset values immediately. An in-flight partial match is lost.

Decomposition:
- Package seq_det_pkg: state enum (IDLE, SCAN, HIT), a helper function for the len-masked compare, and the LEN_W derivation.
- Sub-module seq_match_counter (CNT_W): saturating up-counter with clr and inc inputs, with clr-and-inc giving 1.
- Top level: config registers, history/fill, FSM.

Test Plan:
1. Pattern 3'b101, len=3, overlap=0; in_valid=1 with in=1,0,1,0,1 → detect pulses only after bit 3; match_count=1.
2. Same stream with overlap=1 → detect after bits 3 and 5; match_count=2.
3. Pattern 2'b11, len=2, overlap=1; in=1,1,1,1 → detect high for 3 consecutive cycles (after bits 2, 3, 4); count=3. With overlap=0 → detect after bits 2 and 4 only; count=2.
4. in_valid gaps: pattern 101 fed as 1, gap, 0, gap, gap, 1 → single detect one cycle after the final bit; state and history hold across gaps.
5. Partial match 1,0 on pattern 101, then cfg_load with pattern 4'b0110, len=4 → history cleared; following bits 0,1,1,0 → one detect. With cfg_len=0 or 9 (MAX_LEN=8) → armed=0 and all bits ignored.
6. CNT_W=2: 5 matches → match_count=3 (saturated). cnt_clr coincident with a match → 1. Assert rst_n low mid-pattern → detect=0 and count=0 asynchronously; armed=0 afterwards.
